// File: rtl/rwt_axi4lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : rwt_axi4lite_regfile
// Purpose  : AXI4-Lite slave exposing NUM_REGS 32-bit R/W registers with
//            per-register write pulses. Define RWT_AXI4LITE_REGFILE_WSTRB_EN
//            to honour byte strobes.
// Revision : 1.0 - initial release
// ============================================================================
module rwt_axi4lite_regfile #(
    parameter int          ADDRESS_WIDTH = 16,
    parameter int          NUM_REGS      = 16,
    parameter logic [31:0] RESET_VALUE   = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [ADDRESS_WIDTH-1:0] s_axi_awaddr,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    output logic [1:0]               s_axi_bresp,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    input  logic [ADDRESS_WIDTH-1:0] s_axi_araddr,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);

    localparam int         IDX_W  = ADDRESS_WIDTH - 2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic             ready_en;
    logic             aw_full;
    logic [IDX_W-1:0] aw_idx;
    logic             w_full;
    logic [31:0]      w_data;
    logic [3:0]       w_lanes;
    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             commit;
    logic [IDX_W-1:0] ar_idx;
    logic [31:0]      rd_word;
    logic             rd_hit;
    logic [NUM_REGS-1:0] wr_hit;
    logic             unused_addr_bits;

    // ready_en keeps every ready low until the first edge after reset release
    assign s_axi_awready = ready_en & ~aw_full & ~s_axi_bvalid;
    assign s_axi_wready  = ready_en & ~w_full & ~s_axi_bvalid;
    assign s_axi_arready = ready_en & ~s_axi_rvalid;

    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid & s_axi_wready;
    assign ar_hs  = s_axi_arvalid & s_axi_arready;
    assign commit = aw_full & w_full;
    assign ar_idx = s_axi_araddr[ADDRESS_WIDTH-1:2];
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

`ifdef RWT_AXI4LITE_REGFILE_WSTRB_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            w_lanes <= 4'h0;
        else if (w_hs)
            w_lanes <= s_axi_wstrb;
    end
`else
    logic unused_wstrb;
    assign unused_wstrb = ^s_axi_wstrb;
    assign w_lanes      = 4'hF;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_en     <= 1'b0;
            aw_full      <= 1'b0;
            aw_idx       <= '0;
            w_full       <= 1'b0;
            w_data       <= 32'h0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= OKAY;
            reg_wr_pulse <= '0;
        end else begin
            ready_en     <= 1'b1;
            reg_wr_pulse <= wr_hit;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= s_axi_awaddr[ADDRESS_WIDTH-1:2];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s_axi_wdata;
            end
            if (commit) begin
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= (|wr_hit) ? OKAY : SLVERR;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
                s_axi_bresp  <= OKAY;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [31:0] value;

        // An out-of-range index matches no register, so it commits as SLVERR
        assign wr_hit[i] = commit && (aw_idx == IDX_W'(i));
        assign reg_out[32*i +: 32] = value;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                value <= RESET_VALUE;
            end else if (wr_hit[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_lanes[b])
                        value[8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = 32'h0;
        rd_hit  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_word = reg_out[32*i +: 32];
                rd_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= 32'h0;
            s_axi_rresp  <= OKAY;
        end else if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_word;
            s_axi_rresp  <= rd_hit ? OKAY : SLVERR;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= 32'h0;
            s_axi_rresp  <= OKAY;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rwt_axi4lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_rwt_axi4lite_regfile
// Purpose  : Directed self-checking bench for rwt_axi4lite_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rwt_axi4lite_regfile;

    localparam int          AW    = 16;
    localparam int          NR    = 16;
    localparam logic [31:0] RSTV  = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic          arvalid = 1'b0, rready = 1'b0;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic [NR*32-1:0] reg_out;
    logic [NR-1:0]    reg_wr_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt = 0;
    int resp_cnt  = 0;
    logic [NR-1:0] last_pulse = '0;

    always #5 clk = ~clk;

    rwt_axi4lite_regfile #(.ADDRESS_WIDTH(AW), .NUM_REGS(NR), .RESET_VALUE(RSTV)) dut (
        .clk(clk), .rstn(rstn),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    always @(negedge clk) begin
        if (reg_wr_pulse != '0) begin
            pulse_cnt  = pulse_cnt + $countones(reg_wr_pulse);
            last_pulse = reg_wr_pulse;
        end
        if (bvalid && bready)
            resp_cnt = resp_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input bit accept, output logic [1:0] resp, output int lat,
                             output bit low_ok);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int c = 0;
        low_ok = 1;
        while (!(aw_done && w_done) && c < 50) begin
            if (!aw_done && c >= aw_dly) begin awvalid = 1; awaddr = addr; end
            if (!w_done && c >= w_dly) begin wvalid = 1; wdata = data; wstrb = strb; end
            if ((aw_done && awready) || (w_done && wready)) low_ok = 0;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) begin aw_done = 1; awvalid = 0; end
            if (w_hs)  begin w_done = 1;  wvalid = 0;  end
            c++;
        end
        if (!(aw_done && w_done)) check("wr_handshake_timeout", 0, 1);
        lat = 1;
        while (!bvalid && lat < 20) begin tick(); lat++; end
        resp = bresp;
        if (accept) begin
            bready = 1;
            tick();
            bready = 0;
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input bit accept,
                            output logic [31:0] data, output logic [1:0] resp, output int lat);
        int c = 0;
        arvalid = 1;
        araddr  = addr;
        while (!arready && c < 20) begin tick(); c++; end
        tick();
        arvalid = 0;
        lat = 1;
        while (!rvalid && lat < 20) begin tick(); lat++; end
        data = rdata;
        resp = rresp;
        if (accept) begin
            rready = 1;
            tick();
            rready = 0;
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        logic [NR*32-1:0] snap;
        int lat, p0, r0;
        bit ok, stable, rdy_low;
        logic [31:0] exp_strb;
        logic [1:0]  h_bresp, h_rresp;
        logic [31:0] h_rdata;

        // Reset state
        tick(); tick();
        check("reset_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, reg_wr_pulse}, 64'h0);
        check("reset_reg0", reg_out[31:0], RSTV);
        check("reset_reg15", reg_out[32*15 +: 32], RSTV);
        rstn = 1;
        tick();
        check("ready_after_release", {awready, wready, arready}, 3'b111);

        // Read reset value
        axi_read(16'h0008, 1, data, resp, lat);
        check("rd_reset_data", data, RSTV);
        check("rd_reset_resp", resp, 2'b00);
        check("rd_latency", lat, 1);

        // Same-edge write
        p0 = pulse_cnt; r0 = resp_cnt;
        axi_write(16'h0004, 32'hCAFEBABE, 4'hF, 0, 0, 1, resp, lat, ok);
        check("wr_same_resp", resp, 2'b00);
        check("wr_same_latency", lat, 2);
        check("wr_same_pulse_cnt", pulse_cnt - p0, 1);
        check("wr_same_pulse_vec", last_pulse, 16'h0002);
        check("wr_same_reg1", reg_out[63:32], 32'hCAFEBABE);
        check("wr_same_resp_cnt", resp_cnt - r0, 1);
        axi_read(16'h0004, 1, data, resp, lat);
        check("rb_reg1", data, 32'hCAFEBABE);
        axi_read(16'h0007, 1, data, resp, lat);
        check("rb_reg1_lowbits_ignored", data, 32'hCAFEBABE);

        // AW early, then W early
        r0 = resp_cnt;
        axi_write(16'h000C, 32'h12345678, 4'hF, 0, 3, 1, resp, lat, ok);
        check("aw_first_ready_low", ok, 1);
        check("aw_first_resp", resp, 2'b00);
        check("aw_first_reg3", reg_out[32*3 +: 32], 32'h12345678);
        axi_write(16'h0014, 32'h0BADF00D, 4'hF, 5, 0, 1, resp, lat, ok);
        check("w_first_ready_low", ok, 1);
        check("w_first_reg5", reg_out[32*5 +: 32], 32'h0BADF00D);
        check("split_resp_cnt", resp_cnt - r0, 2);

        // Out of range
        p0 = pulse_cnt; snap = reg_out;
        axi_write(16'h0040, 32'hFFFFFFFF, 4'hF, 0, 0, 1, resp, lat, ok);
        check("oor_bresp", resp, 2'b10);
        check("oor_no_pulse", pulse_cnt - p0, 0);
        check("oor_regs_unchanged", reg_out == snap, 1);
        axi_read(16'h0040, 1, data, resp, lat);
        check("oor_rresp", resp, 2'b10);
        check("oor_rdata", data, 32'h0);

        // Byte strobes
        axi_write(16'h0008, 32'h11223344, 4'hF, 0, 0, 1, resp, lat, ok);
        p0 = pulse_cnt;
        axi_write(16'h0008, 32'hAABBCCDD, 4'b0101, 0, 0, 1, resp, lat, ok);
`ifdef RWT_AXI4LITE_REGFILE_WSTRB_EN
        exp_strb = 32'h11BB33DD;
`else
        exp_strb = 32'hAABBCCDD;
`endif
        check("strb_reg2", reg_out[32*2 +: 32], exp_strb);
        check("strb_pulse", pulse_cnt - p0, 1);

        // Commit and read of the same register on the same edge
        awvalid = 1; awaddr = 16'h0004; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 1; araddr = 16'h0004;
        check("coll_arready", arready, 1);
        tick();
        arvalid = 0;
        check("coll_read_old", {rvalid, rdata}, {1'b1, 32'hCAFEBABE});
        check("coll_reg1_new", {bvalid, reg_out[63:32]}, {1'b1, 32'hDEADBEEF});
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;

        // Back-pressure hold, then reset mid-hold
        r0 = resp_cnt;
        axi_write(16'h0018, 32'h55AA55AA, 4'hF, 0, 0, 0, resp, lat, ok);
        axi_read(16'h000C, 0, data, resp, lat);
        h_bresp = bresp; h_rresp = rresp; h_rdata = rdata;
        stable = 1; rdy_low = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bvalid || !rvalid || bresp !== h_bresp || rresp !== h_rresp || rdata !== h_rdata)
                stable = 0;
            if (awready || wready || arready) rdy_low = 0;
        end
        check("hold_stable", stable, 1);
        check("hold_rdata", h_rdata, 32'h12345678);
        check("hold_readies_low", rdy_low, 1);
        #2;
        rstn = 0;
        #1;
        check("midrst_valids", {bvalid, rvalid, awready, wready, arready}, 5'b0);
        check("midrst_reg1", reg_out[63:32], RSTV);
        check("midrst_reg6", reg_out[32*6 +: 32], RSTV);
        tick();
        rstn = 1;
        tick(); tick(); tick();
        check("post_rst_no_resp", {bvalid, rvalid, 4'(resp_cnt - r0)}, 6'b0);
        check("post_rst_ready", {awready, wready, arready}, 3'b111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
